// File: rtl/blink_mmu.sv
// Blink MMU: COM/segment registers, CPU-to-physical translation, chip-select decode
// and per-device wait-state generation for the Z88 core.
module blink_mmu #(
  parameter int unsigned NSEG       = 4,
  parameter int unsigned BANK_W     = 8,
  parameter bit          SEG0_SPLIT = 1'b1,
  parameter int unsigned RAMS_BANK  = 32'h20,
  parameter logic [7:0]  COM_ADDR   = 8'hB0,
  parameter logic [7:0]  SR_BASE    = 8'hD0,
  parameter int unsigned WS_ROM     = 1,
  parameter int unsigned WS_RAM     = 0,
  parameter int unsigned WS_SLOT    = 2,
  localparam int unsigned SEG_W     = $clog2(NSEG),
  localparam int unsigned SEG_AW    = 16 - SEG_W,
  localparam int unsigned PA_W      = BANK_W + SEG_AW
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     cpu_a,
  input  logic [7:0]      cpu_do,
  input  logic            mreq_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic            wr_n,
  input  logic            m1_n,
  output logic [PA_W-1:0] pa,
  output logic [4:0]      cs_n,
  output logic            oe_n,
  output logic            we_n,
  output logic            wait_n,
  output logic            io_hit,
  output logic [7:0]      io_do,
  output logic [7:0]      com_o
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  logic [7:0]        com_q;
  logic [BANK_W-1:0] sr_q [NSEG];
  logic              iorq_wr_q;
  logic              mreq_q;
  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wait_n_q;

  logic [SEG_W-1:0]  seg;
  logic [SEG_AW-1:0] off;
  logic [BANK_W-1:0] bank;
  logic [2:0]        top3;
  logic [4:0]        dev_sel;
  logic [3:0]        ws;

  assign seg  = cpu_a[15 -: SEG_W];
  assign off  = cpu_a[SEG_AW-1:0];
  assign top3 = bank[BANK_W-1 -: 3];

  always_comb begin
    bank = sr_q[seg];
    // Lower half of segment 0 is hard-wired to bank 0 or the RAMS bank.
    if (SEG0_SPLIT && (seg == '0) && !off[SEG_AW-1]) begin
      bank = com_q[2] ? BANK_W'(RAMS_BANK) : '0;
    end
  end

  assign pa = {bank, off};

  always_comb begin
    dev_sel = 5'b00000;
    if (top3 == 3'b000)      dev_sel = 5'b00001;
    else if (top3 == 3'b001) dev_sel = 5'b00010;
    else begin
      case (top3[2:1])
        2'b01:   dev_sel = 5'b00100;
        2'b10:   dev_sel = 5'b01000;
        default: dev_sel = 5'b10000;
      endcase
    end
  end

  always_comb begin
    ws = 4'(WS_SLOT);
    unique case (1'b1)
      dev_sel[0]: ws = 4'(WS_ROM);
      dev_sel[1]: ws = 4'(WS_RAM);
      default:    ws = 4'(WS_SLOT);
    endcase
  end

  assign cs_n = mreq_n ? 5'b11111 : ~dev_sel;
  assign oe_n = mreq_n | rd_n;
  assign we_n = mreq_n | wr_n;

  // IO port decode; a concurrent memory request always wins over IO.
  logic             io_rd;
  logic             io_wr;
  logic             com_sel;
  logic             sr_sel;
  logic [7:0]       sr_off;
  logic [SEG_W-1:0] sr_idx;
  logic [BANK_W-1:0] sr_wdata;

  assign io_rd    = !iorq_n && !rd_n && m1_n && mreq_n;
  assign io_wr    = !iorq_n && !wr_n && m1_n && mreq_n;
  assign com_sel  = (cpu_a[7:0] == COM_ADDR);
  assign sr_off   = cpu_a[7:0] - SR_BASE;
  assign sr_sel   = !com_sel && (sr_off < 8'(NSEG));
  assign sr_idx   = sr_off[SEG_W-1:0];
  // Bank bits above 8 come from the upper address byte (B register of OUT (C),r).
  assign sr_wdata = BANK_W'({cpu_a[15:8], cpu_do});

  assign io_hit = io_rd && (com_sel || sr_sel);

  always_comb begin
    io_do = 8'h00;
    if (io_hit) io_do = com_sel ? com_q : 8'(sr_q[sr_idx]);
  end

  assign com_o = com_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      iorq_wr_q <= 1'b0;
      com_q     <= 8'h00;
      for (int i = 0; i < NSEG; i++) sr_q[i] <= '0;
    end else begin
      iorq_wr_q <= io_wr;
      if (io_wr && !iorq_wr_q) begin
        if (com_sel)     com_q        <= cpu_do;
        else if (sr_sel) sr_q[sr_idx] <= sr_wdata;
      end
    end
  end

  // Wait-state FSM; N is captured into cnt_q when the access starts.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      wait_n_q <= 1'b1;
      mreq_q   <= 1'b1;
    end else begin
      mreq_q <= mreq_n;
      case (state_q)
        StIdle: begin
          if (!mreq_n && mreq_q) begin
            if (ws != 4'd0) begin
              state_q  <= StWait;
              cnt_q    <= ws - 4'd1;
              wait_n_q <= 1'b0;
            end else begin
              state_q <= StHold;
            end
          end
        end
        StWait: begin
          if (mreq_n) begin
            state_q  <= StIdle;
            wait_n_q <= 1'b1;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            wait_n_q <= 1'b1;
            state_q  <= StHold;
          end
        end
        StHold: begin
          if (mreq_n) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wait_n = wait_n_q;

endmodule

// File: tb/tb_blink_mmu.sv
// Directed bench for blink_mmu: translation, decode, IO register access and wait states.
module tb_blink_mmu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        mreq_n, iorq_n, rd_n, wr_n, m1_n;

  logic [21:0] pa, pa8;
  logic [4:0]  cs_n, cs_n8;
  logic        oe_n, we_n, wait_n, io_hit;
  logic        oe_n8, we_n8, wait_n8, io_hit8;
  logic [7:0]  io_do, com_o, io_do8, com_o8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blink_mmu #(.WS_SLOT(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .pa(pa), .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n), .wait_n(wait_n),
    .io_hit(io_hit), .io_do(io_do), .com_o(com_o)
  );

  blink_mmu #(.NSEG(8), .BANK_W(9)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
    .pa(pa8), .cs_n(cs_n8), .oe_n(oe_n8), .we_n(we_n8), .wait_n(wait_n8),
    .io_hit(io_hit8), .io_do(io_do8), .com_o(com_o8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] hi, input logic [7:0] port, input logic [7:0] data);
    cpu_a  = {hi, port};
    cpu_do = data;
    iorq_n = 1'b0;
    wr_n   = 1'b0;
    tick();
    iorq_n = 1'b1;
    wr_n   = 1'b1;
    tick();
  endtask

  task automatic io_read(input string tag, input logic [7:0] port, input logic [7:0] exp);
    cpu_a  = {8'h00, port};
    iorq_n = 1'b0;
    rd_n   = 1'b0;
    #1;
    check({tag, "_hit"}, io_hit, 1);
    check({tag, "_do"}, io_do, exp);
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    tick();
  endtask

  task automatic mem_read(input string tag, input logic [15:0] addr, input logic [21:0] exp_pa,
                          input logic [4:0] exp_cs, input int exp_wait);
    int lows;
    cpu_a  = addr;
    mreq_n = 1'b0;
    rd_n   = 1'b0;
    #1;
    check({tag, "_pa"}, pa, exp_pa);
    check({tag, "_cs"}, cs_n, exp_cs);
    check({tag, "_oe"}, oe_n, 0);
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (wait_n === 1'b0) lows++;
    end
    check({tag, "_wait"}, lows, exp_wait);
    mreq_n = 1'b1;
    rd_n   = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_a = 16'h0000; cpu_do = 8'h00;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_wait", wait_n, 1);
    check("rst_cs", cs_n, 5'b11111);
    check("rst_iohit", io_hit, 0);
    check("rst_pa", pa, 0);
    check("rst_com", com_o, 0);
    io_read("rst_sr0", 8'hD0, 8'h00);
    io_read("rst_sr3", 8'hD3, 8'h00);

    // SR2 = 21h, translate 8123h into RAM bank 21h
    io_write(8'h00, 8'hD2, 8'h21);
    mem_read("sr2", 16'h8123, 22'h084123, 5'b11101, 0);
    io_read("in_d2", 8'hD2, 8'h21);

    // Memory write strobe
    cpu_a = 16'h8123; mreq_n = 1'b0; wr_n = 1'b0;
    #1;
    check("wr_we", we_n, 0);
    check("wr_oe", oe_n, 1);
    mreq_n = 1'b1; wr_n = 1'b1;
    tick(); tick();

    // Segment-0 lower half follows COM[2]
    io_write(8'h00, 8'hB0, 8'h04);
    check("com04", com_o, 8'h04);
    mem_read("rams", 16'h0010, 22'h080010, 5'b11101, 0);
    io_write(8'h00, 8'hB0, 8'h00);
    mem_read("rom", 16'h0010, 22'h000010, 5'b11110, 1);
    // Segment-0 upper half uses SR0 (still 0)
    mem_read("seg0hi", 16'h2345, 22'h002345, 5'b11110, 1);

    // Card slot 3 with 3 wait states
    io_write(8'h00, 8'hD3, 8'hC5);
    mem_read("slot3", 16'hC000, 22'h314000, 5'b01111, 3);

    // Aborted access: mreq_n released after one clock
    cpu_a = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    check("abort_low", wait_n, 0);
    mreq_n = 1'b1; rd_n = 1'b1;
    tick();
    check("abort_rel", wait_n, 1);
    mem_read("after_abort", 16'hC000, 22'h314000, 5'b01111, 3);

    // Memory request beats a simultaneous IO request
    cpu_a = 16'h00B0; mreq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("prio_hit", io_hit, 0);
    rd_n = 1'b1; wr_n = 1'b0; cpu_do = 8'hFF;
    tick();
    check("prio_com", com_o, 8'h00);
    mreq_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
    tick(); tick();

    // Interrupt acknowledge is not an IO read
    cpu_a = 16'h00D2; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0;
    #1;
    check("intack_hit", io_hit, 0);
    check("intack_do", io_do, 8'h00);
    iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
    tick();

    // Long IO write: only the first data byte lands
    cpu_a = 16'h00D1; iorq_n = 1'b0; wr_n = 1'b0;
    cpu_do = 8'h11; tick();
    cpu_do = 8'h22; tick();
    cpu_do = 8'h33; tick();
    cpu_do = 8'h44; tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
    io_read("sr1_once", 8'hD1, 8'h11);

    // Out-of-range SR port is ignored
    io_write(8'h00, 8'hD5, 8'h77);
    io_read("d5_sr0", 8'hD0, 8'h00);
    io_read("d5_sr1", 8'hD1, 8'h11);
    io_read("d5_sr2", 8'hD2, 8'h21);
    io_read("d5_sr3", 8'hD3, 8'hC5);
    check("d5_com", com_o, 8'h00);

    // Reset during a 3-clock wait
    cpu_a = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0;
    tick(); tick();
    check("mid_wait", wait_n, 0);
    reset_n = 1'b0;
    tick();
    check("rst_mid_wait", wait_n, 1);
    reset_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
    tick();
    check("rst2_com", com_o, 8'h00);
    io_read("rst2_sr2", 8'hD2, 8'h00);
    io_read("rst2_sr3", 8'hD3, 8'h00);

    // NSEG=8, BANK_W=9: SR7 = 1FFh via upper address byte
    io_write(8'h01, 8'hD7, 8'hFF);
    cpu_a = 16'h00D7; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("n8_hit", io_hit8, 1);
    check("n8_do", io_do8, 8'hFF);
    check("n4_d7_hit", io_hit, 0);
    iorq_n = 1'b1; rd_n = 1'b1;
    tick();
    cpu_a = 16'hF234; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    check("n8_pa", pa8, 22'h3FF234);
    check("n8_cs", cs_n8, 5'b01111);
    mreq_n = 1'b1; rd_n = 1'b1;
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
